display_scan_mux: RTL and testbench
===================================

Name: display_scan_mux

Overview:
- Upstream feeder for the hex seven-segment decoder on the multi-digit display.
- Holds a multi-digit hex value and time-multiplexes it onto one shared 4-bit digit bus, which drives the decoder's B input.
- Drives the per-digit anode enables, with dead-time (anti-ghosting), tear-free value update and optional leading-zero blanking.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits; legal range 1..8
REFRESH_DIV, 50000, clock cycles per digit slot; must be >= 2
DEAD_CYCLES, 2, cycles at the start of each slot with all anodes off; must be < REFRESH_DIV

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
value_in  in  4*NUM_DIGITS  value to display; nibble i feeds digit i (digit 0 = LS nibble)
load  in  1  1-cycle strobe: capture value_in into the pending register
blank_lz  in  1  1 = suppress leading-zero digits
digit_out  out  4  nibble of the currently scanned digit, to the decoder B input
digit_en  out  NUM_DIGITS  active-low anode enables; at most one bit low at any time
digit_blank  out  1  1 = current slot is dead-time or blanked; segments must be treated as off
frame_start  out  1  1-cycle pulse when the scan wraps to digit 0

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - div_cnt=0, idx=0, disp_reg=0, pend_reg=0, pend=0.
  - digit_out=0, digit_en=all 1s, digit_blank=1, frame_start=0.
- All outputs are registers. There is no combinational path from any input to any output.
- Outputs in any cycle are consistent with div_cnt and idx in that same cycle.
- Slot counter:
  - div_cnt counts 0..REFRESH_DIV-1.
  - At div_cnt==REFRESH_DIV-1, div_cnt goes to 0 and idx goes to (idx+1) mod NUM_DIGITS.
  - NUM_DIGITS=1: idx stays 0 and every slot end is a wrap.
- Within a slot:
  - digit_out = disp_reg nibble idx for the whole slot.
  - div_cnt < DEAD_CYCLES: digit_en all 1s, digit_blank=1.
  - Otherwise: digit_en bit idx = 0, other bits 1, digit_blank=0, unless the digit is blanked (see below).
- Load/commit (double buffering):
  - load=1 at an edge: pend_reg <= value_in, pend <= 1.
  - Commit happens at the wrap edge (idx N-1 to 0). If pend=1: disp_reg <= pend_reg, pend <= 0.
  - So a new value first appears at digit 0 of the next frame; a frame never mixes old and new digits.
- Same-edge load and commit:
  - The commit uses pend_reg as it was before the edge.
  - pend_reg takes value_in and pend stays 1, so the newer value commits at the following wrap.
- Repeated loads before a commit: the last one wins.
- frame_start = 1 exactly in the first cycle of each idx=0 slot. This includes the very first slot after reset release.
- Leading-zero blanking (blank_lz sampled live):
  - Digit i>0 is blanked when disp_reg nibbles i..NUM_DIGITS-1 are all zero.
  - Digit 0 is never blanked.
  - A blanked digit keeps digit_en all 1s and digit_blank=1 for the whole slot; digit_out still shows the nibble.
- Reset mid-slot or mid-frame: immediate return to the reset state; the pending value is lost.
- Any change in digit_en passes through all 1s for at least DEAD_CYCLES cycles. Two anode bits are never low in the same cycle.

Test Plan:
- Basic scan:
  - Setup: NUM_DIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=1. Release rst, load 16'h1234 in cycle 0.
  - Frame 1 shows all zeros.
  - From the next frame_start, per slot: digit_out=4,3,2,1 and digit_en=1110,1101,1011,0111 in cycles 1..3 of each slot; 1111 in cycle 0.
- Tear-free update:
  - Load 16'hABCD while idx=2 of a frame showing 1234.
  - Slots 2,3 still show 2,1; the next frame shows D,C,B,A.
  - frame_start pulses once per 16 cycles.
- Load at wrap edge:
  - Load 16'h1111 then 16'h2222 on the same edge as the commit.
  - The next frame shows 1111, the following frame 2222.
- Leading-zero blanking:
  - blank_lz=1, display 16'h0050: digits 3,2 have digit_en=1111 and digit_blank=1 for the full slot.
  - Digit 1 is enabled with digit_out=5; digit 0 is enabled with digit_out=0.
  - Display 16'h0000: only digit 0 is enabled.
- Async reset mid-slot:
  - Assert rst at div_cnt=2, idx=3, with pend=1.
  - Outputs return to reset values in the same cycle, without waiting for a clock edge.
  - After release, the first frame shows 0000.
- Exclusivity: random loads and blank_lz over 10k cycles. A checker asserts that digit_en never has more than one zero and that digit_blank=1 whenever digit_en is all 1s.

Source files
------------

// File: rtl/display_scan_mux.sv
// Time-multiplexed hex digit scanner: drives one shared nibble bus plus active-low anodes,
// with per-slot dead-time, frame-aligned double-buffered updates and leading-zero blanking.
module display_scan_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [3:0]              digit_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    digit_blank,
  output logic                    frame_start
);
  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0] DEAD_L   = DIV_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic                    r_run;
  logic [DIV_W-1:0]        r_div;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_disp;
  logic [4*NUM_DIGITS-1:0] r_pend_reg;
  logic                    r_pend;

  logic                    w_div_last;
  logic                    w_wrap;
  logic [DIV_W-1:0]        w_div_nxt;
  logic [IDX_W-1:0]        w_idx_nxt;
  logic [4*NUM_DIGITS-1:0] w_disp_nxt;
  logic [NUM_DIGITS-1:0]   w_lz;
  logic [NUM_DIGITS-1:0]   w_en_nxt;
  logic [3:0]              w_nib [NUM_DIGITS];
  logic                    w_show;

  // r_run holds the counters at zero for one edge after reset so the first slot
  // gets a full-length first cycle carrying frame_start.
  assign w_div_last = (r_div == DIV_LAST);
  assign w_wrap     = r_run && w_div_last && (r_idx == IDX_LAST);
  assign w_div_nxt  = (!r_run || w_div_last) ? '0 : r_div + 1'b1;
  assign w_idx_nxt  = (!r_run || w_wrap) ? '0 : (w_div_last ? r_idx + 1'b1 : r_idx);
  assign w_disp_nxt = (w_wrap && r_pend) ? r_pend_reg : r_disp;

  // Outputs are registered from next-state values so they line up with the counters.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign w_nib[gi] = w_disp_nxt[4*gi +: 4];
      if (gi == 0) begin : g_lsd
        assign w_lz[gi] = 1'b0;
      end else begin : g_upper
        assign w_lz[gi] = (w_disp_nxt[4*NUM_DIGITS-1:4*gi] == '0);
      end
      assign w_en_nxt[gi] = ~(w_show && (w_idx_nxt == IDX_W'(gi)));
    end
  endgenerate

  assign w_show = (w_div_nxt >= DEAD_L) && !(blank_lz && w_lz[w_idx_nxt]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run       <= 1'b0;
      r_div       <= '0;
      r_idx       <= '0;
      r_disp      <= '0;
      r_pend_reg  <= '0;
      r_pend      <= 1'b0;
      digit_out   <= 4'h0;
      digit_en    <= '1;
      digit_blank <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      r_run  <= 1'b1;
      r_div  <= w_div_nxt;
      r_idx  <= w_idx_nxt;
      r_disp <= w_disp_nxt;
      // A load on the commit edge lands in the buffer and waits for the next wrap.
      if (load) begin
        r_pend_reg <= value_in;
        r_pend     <= 1'b1;
      end else if (w_wrap) begin
        r_pend     <= 1'b0;
      end
      digit_out   <= w_nib[w_idx_nxt];
      digit_en    <= w_en_nxt;
      digit_blank <= !w_show;
      frame_start <= !r_run || w_wrap;
    end
  end
endmodule

// File: tb/tb_display_scan_mux.sv
// Randomized self-checking bench for display_scan_mux against a time-indexed reference model.
module tb_display_scan_mux;
  localparam int N = 4;
  localparam int R = 4;
  localparam int D = 1;
  localparam int FRAME = R * N;
  localparam logic [N+5:0] RST_EXP = {4'h0, {N{1'b1}}, 1'b1, 1'b0};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [4*N-1:0] value_in = '0;
  logic         load = 1'b0;
  logic         blank_lz = 1'b0;
  logic [3:0]   digit_out;
  logic [N-1:0] digit_en;
  logic         digit_blank;
  logic         frame_start;

  int total = 0;
  int bad = 0;

  display_scan_mux #(.NUM_DIGITS(N), .REFRESH_DIV(R), .DEAD_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .value_in(value_in), .load(load), .blank_lz(blank_lz),
    .digit_out(digit_out), .digit_en(digit_en), .digit_blank(digit_blank),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Reference: m_t is the cycle number since the scan started; slot and digit follow by division.
  logic           m_run;
  int             m_t;
  logic [4*N-1:0] m_disp, m_pend_val;
  logic           m_pend;
  logic [N+5:0]   m_exp;
  logic           m_commit;
  logic [N+5:0]   obs;

  assign m_commit = m_run && (((m_t + 1) % FRAME) == 0);
  assign obs = {digit_out, digit_en, digit_blank, frame_start};

  function automatic logic [N+5:0] expect_out(int t, logic [4*N-1:0] disp, logic blz);
    int div, idx;
    logic [4*N-1:0] up;
    logic [N-1:0] en;
    logic show;
    div = t % R;
    idx = (t / R) % N;
    up = disp >> (4 * idx);
    show = (div >= D) && !(blz && idx != 0 && up == '0);
    en = '1;
    if (show) en[idx] = 1'b0;
    return {up[3:0], en, !show, (t % FRAME) == 0};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run <= 1'b0; m_t <= 0; m_disp <= '0; m_pend <= 1'b0; m_pend_val <= '0;
      m_exp <= RST_EXP;
    end else begin
      m_run <= 1'b1;
      m_t <= m_run ? m_t + 1 : 0;
      if (m_commit && m_pend) m_disp <= m_pend_val;
      if (load) begin
        m_pend_val <= value_in;
        m_pend <= 1'b1;
      end else if (m_commit) begin
        m_pend <= 1'b0;
      end
      m_exp <= expect_out(m_run ? m_t + 1 : 0, (m_commit && m_pend) ? m_pend_val : m_disp, blank_lz);
    end
  end

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (obs !== RST_EXP) begin
        bad++; $display("FAIL reset_state got=%h exp=%h", obs, RST_EXP);
      end
    end
  endtask

  task automatic test_basic_scan();
    @(negedge clk);
    rst = 1'b0; load = 1'b1; value_in = 16'h1234;
    for (int k = 0; k < 3 * FRAME + 2; k++) begin
      @(negedge clk);
      load = 1'b0;
      total++;
      if (obs !== m_exp) begin
        bad++; $display("FAIL basic_scan t=%0d got=%h exp=%h", m_t, obs, m_exp);
      end
    end
  endtask

  task automatic test_tear_free();
    int fs_cnt = 0;
    for (int k = 0; k < 2 * FRAME && !((m_t / R) % N == 2 && m_t % R == 0); k++) @(negedge clk);
    total++;
    if (!((m_t / R) % N == 2 && m_t % R == 0)) begin
      bad++; $display("FAIL tear_free_wait got=t%0d exp=idx2", m_t);
    end
    load = 1'b1; value_in = 16'hABCD;
    for (int k = 0; k < 2 * FRAME + 8; k++) begin
      @(negedge clk);
      load = 1'b0;
      if (k < 2 * FRAME && frame_start) fs_cnt++;
      total++;
      if (obs !== m_exp) begin
        bad++; $display("FAIL tear_free t=%0d got=%h exp=%h", m_t, obs, m_exp);
      end
    end
    total++;
    if (fs_cnt !== 2) begin
      bad++; $display("FAIL frame_start_rate got=%0d exp=2", fs_cnt);
    end
  endtask

  task automatic test_load_at_wrap();
    for (int k = 0; k < 2 * FRAME && m_t % FRAME != 5; k++) @(negedge clk);
    load = 1'b1; value_in = 16'h1111;
    @(negedge clk);
    load = 1'b0;
    for (int k = 0; k < 2 * FRAME && m_t % FRAME != 15; k++) @(negedge clk);
    total++;
    if (m_t % FRAME != 15) begin
      bad++; $display("FAIL wrap_wait got=t%0d exp=slot_end", m_t);
    end
    load = 1'b1; value_in = 16'h2222;
    for (int k = 0; k < 2 * FRAME + 4; k++) begin
      @(negedge clk);
      load = 1'b0;
      total++;
      if (obs !== m_exp) begin
        bad++; $display("FAIL load_at_wrap t=%0d got=%h exp=%h", m_t, obs, m_exp);
      end
    end
  endtask

  task automatic test_blank_lz();
    logic [4*N-1:0] vals [2];
    vals[0] = 16'h0050;
    vals[1] = 16'h0000;
    blank_lz = 1'b1;
    for (int v = 0; v < 2; v++) begin
      @(negedge clk);
      load = 1'b1; value_in = vals[v];
      for (int k = 0; k < 3 * FRAME; k++) begin
        @(negedge clk);
        load = 1'b0;
        total++;
        if (obs !== m_exp) begin
          bad++; $display("FAIL blank_lz v=%h t=%0d got=%h exp=%h", vals[v], m_t, obs, m_exp);
        end
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 2 * FRAME && m_t % FRAME != 4; k++) @(negedge clk);
    load = 1'b1; value_in = 16'h9999;
    @(negedge clk);
    load = 1'b0;
    for (int k = 0; k < 2 * FRAME && m_t % FRAME != 14; k++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (obs !== RST_EXP) begin
      bad++; $display("FAIL async_reset got=%h exp=%h", obs, RST_EXP);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2 * FRAME + 2; k++) begin
      @(negedge clk);
      total++;
      if (obs !== m_exp) begin
        bad++; $display("FAIL after_reset t=%0d got=%h exp=%h", m_t, obs, m_exp);
      end
    end
  endtask

  task automatic test_exclusivity();
    logic [N-1:0] last_en = '1;
    int ones_run = D;
    for (int k = 0; k < 10000; k++) begin
      @(negedge clk);
      load = 1'b0;
      total++;
      if (obs !== m_exp) begin
        bad++; $display("FAIL random_model t=%0d got=%h exp=%h", m_t, obs, m_exp);
      end
      total++;
      if ($countones(~digit_en) > 1 || (digit_en == '1 && digit_blank !== 1'b1)) begin
        bad++; $display("FAIL exclusivity t=%0d got=en%b/bl%b exp=one_low", m_t, digit_en, digit_blank);
      end
      if (digit_en == '1) begin
        ones_run++;
      end else begin
        total++;
        if (last_en != '1 && digit_en != last_en && ones_run < D) begin
          bad++; $display("FAIL dead_time t=%0d got=%0d exp>=%0d", m_t, ones_run, D);
        end
        last_en = digit_en;
        ones_run = 0;
      end
      if ($urandom % 8 == 0) begin
        load = 1'b1;
        value_in = 16'($urandom) >> ($urandom % 16);
      end
      if ($urandom % 64 == 0) blank_lz = ~blank_lz;
    end
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_tear_free();
    test_load_at_wrap();
    test_blank_lz();
    test_async_reset();
    test_exclusivity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
